// File: rtl/alu_writeback.sv
// alu_writeback: writeback end of the 4-bit signed ALU path.
// Takes ALU results through a valid/ready handshake and commits them to the
// register file with a three-state FSM (IDLE -> LATCH -> COMMIT). While a
// write is in flight, reads of its address return the pending value.
// It also keeps a sticky overflow flag and a wrapping commit counter.
// Optional feature: define WB_SATURATE_EN to saturate overflowed results
// instead of writing the wrapped two's complement value.
module alu_writeback #(
  parameter int DATA_W = 4,
  parameter int NREG   = 4,
  parameter int ADDR_W = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_ovf,
  output logic              wr_done,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] Rd1,
  output logic [DATA_W-1:0] Rd2,
  output logic              ovf_flag,
  input  logic              clr_ovf,
  output logic [CNT_W-1:0]  commit_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LATCH  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Pending entry captured at the handshake.
  logic              pend_valid_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [DATA_W-1:0] pend_data_q;
  logic              pend_ovf_q;
  // Final write value, registered at the LATCH edge.
  logic [DATA_W-1:0] val_q;
  logic [DATA_W-1:0] wb_val;

  logic              wr_done_q;
  logic              ovf_q;
  logic [CNT_W-1:0]  cnt_q;

  // Register 0 is hardwired to zero, so only 1..NREG-1 get storage.
  logic [DATA_W-1:0] regs_q [1:NREG-1];

  logic accept;
  logic in_flight;

  assign accept    = (state_q == IDLE) && wr_valid;
  assign in_flight = (state_q == LATCH) || (state_q == COMMIT);

  // Final write value from the pending entry (optionally saturated).
  always_comb begin
    wb_val = pend_data_q;
`ifdef WB_SATURATE_EN
    if (pend_ovf_q) begin
      // A set sign bit means a positive result wrapped negative, and the reverse.
      if (pend_data_q[DATA_W-1]) begin
        wb_val = {1'b0, {(DATA_W-1){1'b1}}};
      end else begin
        wb_val = {1'b1, {(DATA_W-1){1'b0}}};
      end
    end
`endif
  end

  // Next-state logic and handshake ready.
  always_comb begin
    state_d  = state_q;
    wr_ready = 1'b0;
    case (state_q)
      IDLE: begin
        wr_ready = 1'b1;
        if (wr_valid) state_d = LATCH;
      end
      LATCH:   state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Pending entry: capture on handshake, finalise in LATCH, retire at COMMIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      pend_ovf_q   <= 1'b0;
      val_q        <= '0;
    end else begin
      if (accept) begin
        pend_valid_q <= 1'b1;
        pend_addr_q  <= wr_addr;
        pend_data_q  <= wr_data;
        pend_ovf_q   <= wr_ovf;
      end else if (state_q == COMMIT) begin
        pend_valid_q <= 1'b0;
      end
      if (state_q == LATCH) val_q <= wb_val;
    end
  end

  // Register file storage: one writable register per nonzero address.
  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_reg
      // Commit the final value when the pending address selects this register.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          regs_q[gi] <= '0;
        end else if (state_q == COMMIT && pend_addr_q == ADDR_W'(gi)) begin
          regs_q[gi] <= val_q;
        end
      end
    end
  endgenerate

  // Status: done pulse, sticky overflow (set beats clear), commit counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_done_q <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      wr_done_q <= (state_q == COMMIT);
      if (state_q == COMMIT) cnt_q <= cnt_q + 1'b1;
      if (state_q == COMMIT && pend_ovf_q) ovf_q <= 1'b1;
      else if (clr_ovf)                    ovf_q <= 1'b0;
    end
  end

  // Two read ports sharing the same lookup and bypass logic.
  logic [ADDR_W-1:0] rd_addr_a [2];
  logic [DATA_W-1:0] rd_data_a [2];

  assign rd_addr_a[0] = rd_addr1;
  assign rd_addr_a[1] = rd_addr2;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      // Address 0 reads zero; an in-flight write to the same address bypasses the array.
      always_comb begin
        rd_data_a[gi] = '0;
        if (rd_addr_a[gi] != '0) begin
          if (in_flight && pend_valid_q && rd_addr_a[gi] == pend_addr_q) begin
            rd_data_a[gi] = (state_q == COMMIT) ? val_q : wb_val;
          end else begin
            rd_data_a[gi] = regs_q[rd_addr_a[gi]];
          end
        end
      end
    end
  endgenerate

  assign Rd1        = rd_data_a[0];
  assign Rd2        = rd_data_a[1];
  assign wr_done    = wr_done_q;
  assign ovf_flag   = ovf_q;
  assign commit_cnt = cnt_q;

endmodule
